// File: rtl/uart_apb_regs_if.sv
// APB3 bus bundle between the bus master and the UART register block.
interface uart_apb_regs_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/uart_apb_regs.sv
// APB slave register block for the UART: DATA/CTRL/STAT/INT map, bounded
// wait states on FIFO back-pressure, PSLVERR on illegal accesses.
// Optional sticky W1C interrupt register and irq output: define UART_INT_EN.
module uart_apb_regs #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int DBITS      = 8,
   parameter int WAIT_MAX   = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_apb_regs_if.slave   apb,
   input  logic             full_tx_i,
   input  logic             empty_rx_i,
   input  logic [DBITS-1:0] rx_dout_fifo_i,
   input  logic             tx_busy_i,
   input  logic             rx_busy_i,
   input  logic             rx_ready_i,
   input  logic             rx_error_i,
   output logic             wr_en_o,
   output logic [DBITS-1:0] tx_din_fifo_o,
   output logic             tx_start_o,
   output logic             rd_en_o,
   output logic [1:0]       clk_freq_index_o,
   output logic [1:0]       baud_rate_index_o,
   output logic             irq_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [5:0]            ctrl_q, ctrl_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic [DBITS-1:0]      txd_q, txd_d;
   logic [2:0]            int_rd;

   // Address decode; anything outside the four word addresses is illegal
   logic sel_data, sel_ctrl, sel_stat, sel_int, legal;
   assign sel_data = (apb.PADDR == ADDR_WIDTH'(0));
   assign sel_ctrl = (apb.PADDR == ADDR_WIDTH'(4));
   assign sel_stat = (apb.PADDR == ADDR_WIDTH'(8));
   assign sel_int  = (apb.PADDR == ADDR_WIDTH'(12));
   assign legal    = sel_data | sel_ctrl | sel_stat | sel_int;

   logic       access, blocked, err_now;
   logic [5:0] stat;
   logic [8:0] cnt_inc;
   assign access  = apb.PSELx & apb.PENABLE;
   assign blocked = sel_data & (apb.PWRITE ? full_tx_i : empty_rx_i);
   assign err_now = ~legal | (sel_data & ~ctrl_q[0]) | (sel_stat & apb.PWRITE);
   assign stat    = {tx_busy_i, full_tx_i, rx_error_i, rx_busy_i, rx_ready_i, empty_rx_i};
   assign cnt_inc = {1'b0, cnt_q} + 9'd1;

`ifdef UART_INT_EN
   logic [2:0] int_q, int_d, int_clr_d, int_set;
   logic       rx_ready_prev_q, tx_busy_prev_q, irq_q;
`endif

   // Read mux for the register addressed this cycle
   logic [DATA_WIDTH-1:0] rd_val;
   always_comb begin
      rd_val = '0;
      if (sel_data)      rd_val = DATA_WIDTH'(rx_dout_fifo_i);
      else if (sel_ctrl) rd_val = DATA_WIDTH'(ctrl_q);
      else if (sel_stat) rd_val = DATA_WIDTH'(stat);
      else if (sel_int)  rd_val = DATA_WIDTH'(int_rd);
   end

   // Transfer FSM: decide, optionally wait on the FIFO, then one response cycle.
   // All response outputs are computed here and registered into the RESP cycle.
   logic complete, cerr;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      txd_d     = '0;
      complete  = 1'b0;
      cerr      = 1'b0;
`ifdef UART_INT_EN
      int_clr_d = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (err_now) begin
                  complete = 1'b1;
                  cerr     = 1'b1;
               end else if (blocked) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end else begin
                  complete = 1'b1;
               end
            end
         end
         S_WAIT: begin
            // master dropped the select: abandon silently
            if (!apb.PSELx) begin
               state_d = S_IDLE;
            end else if (!blocked) begin
               complete = 1'b1;
            end else if (cnt_inc == 9'(WAIT_MAX)) begin
               complete = 1'b1;
               cerr     = 1'b1;
            end else begin
               cnt_d = cnt_inc[7:0];
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (complete) begin
         state_d   = S_RESP;
         pready_d  = 1'b1;
         pslverr_d = cerr;
         if (!cerr) begin
            if (apb.PWRITE) begin
               if (sel_data) begin
                  wr_en_d = 1'b1;
                  txd_d   = apb.PWDATA[DBITS-1:0];
               end
               if (sel_ctrl) ctrl_d = apb.PWDATA[5:0];
`ifdef UART_INT_EN
               if (sel_int) int_clr_d = apb.PWDATA[2:0];
`endif
            end else begin
               prdata_d = rd_val;
               if (sel_data) rd_en_d = 1'b1;
            end
         end
      end
   end

   // State, control register and registered response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ctrl_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         txd_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= ctrl_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         txd_q     <= txd_d;
      end
   end

`ifdef UART_INT_EN
   // Sticky events; a set in the same cycle as its W1C clear wins
   assign int_set = {rx_error_i, tx_busy_prev_q & ~tx_busy_i, rx_ready_i & ~rx_ready_prev_q};
   always_comb int_d = (int_q & ~int_clr_d) | int_set;

   // Interrupt status, edge-detect history and registered irq
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_q           <= '0;
         rx_ready_prev_q <= 1'b0;
         tx_busy_prev_q  <= 1'b0;
         irq_q           <= 1'b0;
      end else begin
         int_q           <= int_d;
         rx_ready_prev_q <= rx_ready_i;
         tx_busy_prev_q  <= tx_busy_i;
         irq_q           <= ctrl_q[1] & (|int_q);
      end
   end

   assign int_rd = int_q;
   assign irq_o  = irq_q;
`else
   assign int_rd = '0;
   assign irq_o  = 1'b0;
`endif

   assign apb.PREADY        = pready_q;
   assign apb.PSLVERR       = pslverr_q;
   assign apb.PRDATA        = prdata_q;
   assign wr_en_o           = wr_en_q;
   assign tx_start_o        = wr_en_q;
   assign tx_din_fifo_o     = txd_q;
   assign rd_en_o           = rd_en_q;
   assign clk_freq_index_o  = ctrl_q[3:2];
   assign baud_rate_index_o = ctrl_q[5:4];

endmodule

// File: tb/tb_uart_apb_regs.sv
// Bench for uart_apb_regs: directed steps plus randomized transfers checked
// against a register-level model of the UART register map.
module tb_uart_apb_regs;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int DB = 8;
   localparam int WM = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_apb_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb();

   logic          full_tx, empty_rx, tx_busy, rx_busy, rx_ready, rx_error;
   logic [DB-1:0] rx_dout;
   logic          wr_en, tx_start, rd_en, irq;
   logic [DB-1:0] tx_din;
   logic [1:0]    cfi, bri;

   uart_apb_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DBITS(DB), .WAIT_MAX(WM)) dut (
      .clk(clk), .rst_n(rst_n), .apb(apb),
      .full_tx_i(full_tx), .empty_rx_i(empty_rx), .rx_dout_fifo_i(rx_dout),
      .tx_busy_i(tx_busy), .rx_busy_i(rx_busy), .rx_ready_i(rx_ready), .rx_error_i(rx_error),
      .wr_en_o(wr_en), .tx_din_fifo_o(tx_din), .tx_start_o(tx_start), .rd_en_o(rd_en),
      .clk_freq_index_o(cfi), .baud_rate_index_o(bri), .irq_o(irq)
   );

   int total = 0;
   int bad = 0;

   // register-level model
   logic [5:0] m_ctrl = '0;
   logic [2:0] m_int = '0;
   logic       fall_on_access = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One APB transfer; the FIFO condition blocks for the first nblk access cycles
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int nblk, output logic [DW-1:0] rd, output logic err,
                       output int lat, output int wc, output int rc,
                       output logic [DB-1:0] txd, output int oddc);
      logic isdata;
      isdata = (addr == '0);
      rd = '0; err = 1'b0; lat = 0; wc = 0; rc = 0; txd = '0; oddc = 0;
      apb.PADDR = addr; apb.PWRITE = wr; apb.PWDATA = wd;
      apb.PSELx = 1'b1; apb.PENABLE = 1'b0;
      @(posedge clk); #1;
      apb.PENABLE = 1'b1;
      if (fall_on_access) tx_busy = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (isdata && wr)  full_tx  = (c <= nblk);
         if (isdata && !wr) empty_rx = (c <= nblk);
         @(posedge clk); #1;
         if (wr_en) begin wc++; txd = tx_din; end
         if (rd_en) rc++;
         if ((wr_en || rd_en) && !apb.PREADY) oddc++;
         if (wr_en && rd_en) oddc++;
         if (tx_start !== wr_en) oddc++;
         if (apb.PSLVERR && !apb.PREADY) oddc++;
         if (apb.PREADY) begin
            lat = c + 1;
            rd  = apb.PRDATA;
            err = apb.PSLVERR;
            break;
         end
      end
      apb.PSELx = 1'b0; apb.PENABLE = 1'b0; full_tx = 1'b0;
      @(posedge clk); #1;
      if (wr_en || rd_en || apb.PREADY || apb.PSLVERR || apb.PRDATA != '0) oddc++;
   endtask

   // Run one transfer and compare everything against the model
   task automatic run(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input int nblk, input string tag);
      logic          legal, isdata, eerr, rdt_err;
      logic [DW-1:0] erd, rd;
      int            elat, lat, wc, rc, oddc;
      logic [DB-1:0] txd;
      logic          e_irq;
      legal  = (addr == 8'h00) || (addr == 8'h04) || (addr == 8'h08) || (addr == 8'h0C);
      isdata = (addr == 8'h00);
      eerr   = !legal || (isdata && !m_ctrl[0]) || (addr == 8'h08 && wr) ||
               (isdata && m_ctrl[0] && nblk > WM);
      elat   = (isdata && m_ctrl[0]) ? ((nblk < WM) ? nblk : WM) + 2 : 2;
      erd    = '0;
      if (!eerr && !wr) begin
         case (addr)
            8'h00:   erd = DW'(rx_dout);
            8'h04:   erd = DW'(m_ctrl);
            8'h08:   erd = DW'({tx_busy, full_tx, rx_error, rx_busy, rx_ready, empty_rx});
            default: erd = DW'(m_int);
         endcase
      end
      xfer(wr, addr, wd, nblk, rd, rdt_err, lat, wc, rc, txd, oddc);
      chk({tag, ".lat"}, lat, elat);
      chk({tag, ".err"}, rdt_err, eerr);
      chk({tag, ".rdata"}, rd, erd);
      chk({tag, ".push"}, wc, (wr && isdata && !eerr) ? 1 : 0);
      chk({tag, ".pop"}, rc, (!wr && isdata && !eerr) ? 1 : 0);
      if (wr && isdata && !eerr) chk({tag, ".txd"}, txd, wd[DB-1:0]);
      chk({tag, ".pulses"}, oddc, 0);
      if (!eerr && wr && addr == 8'h04) m_ctrl = wd[5:0];
`ifdef UART_INT_EN
      if (!eerr && wr && addr == 8'h0C) m_int = m_int & ~wd[2:0];
      if (rx_error) m_int[2] = 1'b1;
      if (fall_on_access) m_int[1] = 1'b1;
`endif
      chk({tag, ".idx"}, {cfi, bri}, {m_ctrl[3:2], m_ctrl[5:4]});
      @(posedge clk); #1;
`ifdef UART_INT_EN
      e_irq = m_ctrl[1] & (|m_int);
`else
      e_irq = 1'b0;
`endif
      chk({tag, ".irq"}, irq, e_irq);
   endtask

   // Change UART status lines; the model records the interrupt events they imply
   task automatic set_status(input logic tb_n, input logic rr_n, input logic rb_n, input logic re_n);
`ifdef UART_INT_EN
      if (rr_n && !rx_ready) m_int[0] = 1'b1;
      if (!tb_n && tx_busy)  m_int[1] = 1'b1;
      if (re_n)              m_int[2] = 1'b1;
`endif
      tx_busy = tb_n; rx_ready = rr_n; rx_busy = rb_n; rx_error = re_n;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;
      int            nb, cnt;
      apb.PADDR = '0; apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PWDATA = '0;
      full_tx = 1'b0; empty_rx = 1'b1; rx_dout = '0;
      tx_busy = 1'b0; rx_busy = 1'b0; rx_ready = 1'b0; rx_error = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.outs", {apb.PREADY, apb.PSLVERR, apb.PRDATA, wr_en, rd_en, irq, cfi, bri}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(1'b0, 8'h04, 16'h0, 0, "rd_ctrl_rst");
      run(1'b0, 8'h08, 16'h0, 0, "rd_stat_rst");
      run(1'b1, 8'h00, 16'h00A5, 0, "data_wr_dis");
      run(1'b1, 8'h04, 16'h0035, 0, "wr_ctrl");
      chk("cfi", cfi, 2'd1);
      chk("bri", bri, 2'd3);
      run(1'b1, 8'h00, 16'h00A5, 0, "wr_data");
      run(1'b1, 8'h00, 16'h0011, 5, "wr_bp5");
      run(1'b1, 8'h00, 16'h0022, 99, "wr_timeout");
      run(1'b1, 8'h00, 16'h0033, WM, "wr_bp_max");
      rx_dout = 8'h3C; empty_rx = 1'b0;
      run(1'b0, 8'h00, 16'h0, 0, "rd_data");
      run(1'b0, 8'h00, 16'h0, WM + 1, "rd_timeout");
      run(1'b0, 8'h14, 16'h0, 0, "rd_illegal");
      run(1'b1, 8'h08, 16'hFFFF, 0, "wr_stat");
      run(1'b0, 8'h08, 16'h0, 0, "rd_stat");

      // interrupt path (model collapses to zero when the feature is absent)
      run(1'b1, 8'h04, 16'h0003, 0, "wr_ctrl_ie");
      set_status(1'b1, 1'b0, 1'b0, 1'b0);
      set_status(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      run(1'b0, 8'h0C, 16'h0, 0, "rd_int_txdone");
      set_status(1'b1, 1'b0, 1'b0, 1'b0);
      fall_on_access = 1'b1;
      run(1'b1, 8'h0C, 16'h0002, 0, "w1c_vs_set");
      fall_on_access = 1'b0;
      run(1'b0, 8'h0C, 16'h0, 0, "rd_int_kept");
      run(1'b1, 8'h0C, 16'h0007, 0, "w1c_all");
      run(1'b0, 8'h0C, 16'h0, 0, "rd_int_clr");

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            rx_dout  = DB'($urandom);
            empty_rx = 1'($urandom);
            set_status(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
         end
         case ($urandom_range(0, 5))
            0, 5: a = 8'h00;
            1:    a = 8'h04;
            2:    a = 8'h08;
            3:    a = 8'h0C;
            default: a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(1, 3));
         endcase
         w = 1'($urandom);
         d = DW'($urandom);
         if (a == 8'h04 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         case ($urandom_range(0, 3))
            1:       nb = $urandom_range(1, WM - 1);
            2:       nb = $urandom_range(WM, WM + 2);
            default: nb = 0;
         endcase
         run(w, a, d, nb, "rand");
      end

      // async reset in the middle of a back-pressured write
      set_status(1'b0, 1'b0, 1'b0, 1'b0);
      run(1'b1, 8'h04, 16'h0001, 0, "wr_ctrl_en");
      apb.PADDR = 8'h00; apb.PWRITE = 1'b1; apb.PWDATA = 16'h0055;
      apb.PSELx = 1'b1; apb.PENABLE = 1'b0; full_tx = 1'b1;
      @(posedge clk); #1;
      apb.PENABLE = 1'b1;
      cnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (apb.PREADY || wr_en || rd_en) cnt++;
      end
      #2 rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (apb.PREADY || wr_en || rd_en || apb.PSLVERR) cnt++;
      end
      chk("rst_wait.quiet", cnt, 0);
      apb.PSELx = 1'b0; apb.PENABLE = 1'b0; full_tx = 1'b0;
      rst_n = 1'b1;
      m_ctrl = '0; m_int = '0;
      @(posedge clk); #1;
      run(1'b0, 8'h04, 16'h0, 0, "rd_ctrl_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
